// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences each instruction through its datapath
// states, handshakes with memory under a wait-state timeout, and halts on traps.
module multicycle_control_fsm #(
  parameter int SUPPORT_SYSTEM = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_memAck,
  output logic       o_memReq,
  output logic       o_memWrite,
  output logic       o_adrSrc,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic       o_branch,
  output logic       o_regWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [2:0] o_immSrc,
  output logic [1:0] o_resultSrc,
  output logic       o_readDataSrc,
  output logic       o_immPlusSrc,
  output logic       o_trap,
  output logic [1:0] o_trapCause,
  output logic       o_halted,
  output logic [3:0] o_state
);

  // With the timeout disabled TW collapses to 0, so the counter keeps at least one bit.
  localparam int             CW    = (TW < 1) ? 1 : TW;
  localparam logic [CW-1:0]  TMAX  = CW'(TIMEOUT_CYCLES);
  localparam bit             TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC_R = 4'd7,
    EXEC_I = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JAL    = 4'd11,
    JALR   = 4'd12,
    UPPER  = 4'd13,
    TRAP   = 4'd14,
    HALT   = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          expired;
  logic          unusedOpcodeBits;

  assign unusedOpcodeBits = ^i_opcode[1:0];
  assign expired          = TO_EN && (cnt_q == TMAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // The counter only survives while a wait state loops on itself; every entry clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cause_d = cause_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (i_memAck)     state_d = DECODE;
        else if (expired) begin state_d = TRAP; cause_d = 2'b11; end
        else              cnt_d = cnt_q + CW'(1);
      end
      DECODE: begin
        casez (i_opcode[6:2])
          5'b00000, 5'b01000: state_d = MEMADR;
          5'b01100:           state_d = EXEC_R;
          5'b00100:           state_d = EXEC_I;
          5'b11000:           state_d = BRANCH;
          5'b11011:           state_d = JAL;
          5'b11001:           state_d = JALR;
          5'b0?101:           state_d = UPPER;
          5'b00011:           state_d = FETCH;
          5'b11100: begin
            state_d = TRAP;
            cause_d = (SUPPORT_SYSTEM != 0) ? 2'b10 : 2'b01;
          end
          default: begin
            state_d = TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      MEMADR: state_d = i_opcode[5] ? MEMWR : MEMRD;
      MEMRD: begin
        if (i_memAck)     state_d = MEMWB;
        else if (expired) begin state_d = TRAP; cause_d = 2'b11; end
        else              cnt_d = cnt_q + CW'(1);
      end
      MEMWR: begin
        if (i_memAck)     state_d = FETCH;
        else if (expired) begin state_d = TRAP; cause_d = 2'b11; end
        else              cnt_d = cnt_q + CW'(1);
      end
      EXEC_R, EXEC_I:                          state_d = ALUWB;
      MEMWB, ALUWB, BRANCH, JAL, JALR, UPPER:  state_d = FETCH;
      TRAP:                                    state_d = HALT;
      HALT:                                    state_d = HALT;
      default:                                 state_d = IDLE;
    endcase
  end

  // Moore decode; IR and PC latch in FETCH are the only ack-gated enables.
  always_comb begin
    o_memReq    = 1'b0;
    o_memWrite  = 1'b0;
    o_adrSrc    = 1'b0;
    o_irWrite   = 1'b0;
    o_pcWrite   = 1'b0;
    o_branch    = 1'b0;
    o_regWrite  = 1'b0;
    o_ALUSrcA   = 2'b00;
    o_ALUSrcB   = 2'b00;
    o_ALUOp     = 2'b00;
    o_resultSrc = 2'b00;
    o_trap      = 1'b0;
    o_halted    = 1'b0;
    case (state_q)
      FETCH: begin
        o_memReq    = 1'b1;
        o_ALUSrcB   = 2'b10;
        o_resultSrc = 2'b10;
        o_irWrite   = i_memAck;
        o_pcWrite   = i_memAck;
      end
      DECODE: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b01;
      end
      MEMADR: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
      end
      MEMRD: begin
        o_memReq = 1'b1;
        o_adrSrc = 1'b1;
      end
      MEMWB: begin
        o_resultSrc = 2'b01;
        o_regWrite  = 1'b1;
      end
      MEMWR: begin
        o_memReq   = 1'b1;
        o_memWrite = 1'b1;
        o_adrSrc   = 1'b1;
      end
      EXEC_R: begin
        o_ALUSrcA = 2'b10;
        o_ALUOp   = 2'b10;
      end
      EXEC_I: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        o_ALUOp   = 2'b10;
      end
      ALUWB: o_regWrite = 1'b1;
      BRANCH: begin
        o_ALUSrcA = 2'b10;
        o_ALUOp   = 2'b01;
        o_branch  = 1'b1;
      end
      JAL: begin
        o_resultSrc = 2'b11;
        o_regWrite  = 1'b1;
        o_pcWrite   = 1'b1;
      end
      JALR: begin
        o_ALUSrcA   = 2'b10;
        o_ALUSrcB   = 2'b01;
        o_resultSrc = 2'b10;
        o_pcWrite   = 1'b1;
        o_regWrite  = 1'b1;
      end
      UPPER: begin
        o_resultSrc = 2'b10;
        o_ALUSrcA   = 2'b01;
        o_ALUSrcB   = 2'b01;
        o_regWrite  = 1'b1;
      end
      TRAP:    o_trap   = 1'b1;
      HALT:    o_halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_immSrc = 3'b000;
    casez (i_opcode[6:2])
      5'b00100: o_immSrc = (i_funct3[1:0] == 2'b01) ? 3'b010 : 3'b001;
      5'b01000: o_immSrc = 3'b011;
      5'b0?101: o_immSrc = 3'b100;
      5'b11000: o_immSrc = 3'b101;
      5'b11001: o_immSrc = 3'b110;
      5'b11011: o_immSrc = 3'b111;
      default:  o_immSrc = 3'b000;
    endcase
  end

  assign o_readDataSrc = i_funct3[2];
  assign o_immPlusSrc  = ~i_opcode[5];
  assign o_trapCause   = cause_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: an instruction-level model expands each instruction
// into its expected per-cycle trace, and a compare process checks the DUT against it.
module tb_multicycle_control_fsm;

  localparam int TO_A  = 4;
  localparam int SUP_A = 1;

  localparam int ST_IDLE = 0,  ST_FETCH = 1,  ST_DECODE = 2, ST_MEMADR = 3;
  localparam int ST_MEMRD = 4, ST_MEMWB = 5,  ST_MEMWR = 6,  ST_EXEC_R = 7;
  localparam int ST_EXEC_I = 8, ST_ALUWB = 9, ST_BRANCH = 10, ST_JAL = 11;
  localparam int ST_JALR = 12, ST_UPPER = 13, ST_TRAP = 14,  ST_HALT = 15;

  typedef struct {
    logic [3:0] st;
    logic       ack;
    logic [1:0] cause;
    logic [6:0] op;
    logic [2:0] f3;
  } cyc_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [6:0] i_opcode = 7'h13;
  logic [2:0] i_funct3 = 3'b000;
  logic       i_memAck = 1'b0;

  logic aMemReq, aMemWrite, aAdrSrc, aIrWrite, aPcWrite, aBranch, aRegWrite;
  logic aReadDataSrc, aImmPlusSrc, aTrap, aHalted;
  logic [1:0] aALUSrcA, aALUSrcB, aALUOp, aResultSrc, aTrapCause;
  logic [2:0] aImmSrc;
  logic [3:0] aState;

  logic bMemReq, bMemWrite, bAdrSrc, bIrWrite, bPcWrite, bBranch, bRegWrite;
  logic bReadDataSrc, bImmPlusSrc, bTrap, bHalted;
  logic [1:0] bALUSrcA, bALUSrcB, bALUOp, bResultSrc, bTrapCause;
  logic [2:0] bImmSrc;
  logic [3:0] bState;

  logic [16:0] aCtrl;
  assign aCtrl = {aMemReq, aMemWrite, aAdrSrc, aIrWrite, aPcWrite, aBranch, aRegWrite,
                  aALUSrcA, aALUSrcB, aALUOp, aResultSrc, aTrap, aHalted};

  int   checks = 0;
  int   errors = 0;
  int   reqCount = 0;
  int   trapCount = 0;
  cyc_t stimQ[$];
  cyc_t chkQ[$];
  logic [6:0] curOp = 7'h13;
  logic [2:0] curF3 = 3'b000;
  logic [1:0] curCause = 2'b00;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.SUPPORT_SYSTEM(SUP_A), .TIMEOUT_CYCLES(TO_A)) dutA (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_memAck(i_memAck),
    .o_memReq(aMemReq), .o_memWrite(aMemWrite), .o_adrSrc(aAdrSrc), .o_irWrite(aIrWrite),
    .o_pcWrite(aPcWrite), .o_branch(aBranch), .o_regWrite(aRegWrite), .o_ALUSrcA(aALUSrcA),
    .o_ALUSrcB(aALUSrcB), .o_ALUOp(aALUOp), .o_immSrc(aImmSrc), .o_resultSrc(aResultSrc),
    .o_readDataSrc(aReadDataSrc), .o_immPlusSrc(aImmPlusSrc), .o_trap(aTrap),
    .o_trapCause(aTrapCause), .o_halted(aHalted), .o_state(aState)
  );

  multicycle_control_fsm #(.SUPPORT_SYSTEM(0), .TIMEOUT_CYCLES(0)) dutB (
    .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_memAck(i_memAck),
    .o_memReq(bMemReq), .o_memWrite(bMemWrite), .o_adrSrc(bAdrSrc), .o_irWrite(bIrWrite),
    .o_pcWrite(bPcWrite), .o_branch(bBranch), .o_regWrite(bRegWrite), .o_ALUSrcA(bALUSrcA),
    .o_ALUSrcB(bALUSrcB), .o_ALUOp(bALUOp), .o_immSrc(bImmSrc), .o_resultSrc(bResultSrc),
    .o_readDataSrc(bReadDataSrc), .o_immPlusSrc(bImmPlusSrc), .o_trap(bTrap),
    .o_trapCause(bTrapCause), .o_halted(bHalted), .o_state(bState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected control enables for a state, straight from the per-state output table.
  function automatic logic [16:0] expCtrl(input logic [3:0] st, input logic ack);
    logic memReq, memWrite, adrSrc, irWrite, pcWrite, branch, regWrite, trap, halted;
    logic [1:0] srcA, srcB, aluOp, result;
    {memReq, memWrite, adrSrc, irWrite, pcWrite, branch, regWrite, trap, halted} = '0;
    {srcA, srcB, aluOp, result} = '0;
    case (int'(st))
      ST_FETCH:  begin memReq = 1; srcB = 2; result = 2; irWrite = ack; pcWrite = ack; end
      ST_DECODE: begin srcA = 1; srcB = 1; end
      ST_MEMADR: begin srcA = 2; srcB = 1; end
      ST_MEMRD:  begin memReq = 1; adrSrc = 1; end
      ST_MEMWB:  begin result = 1; regWrite = 1; end
      ST_MEMWR:  begin memReq = 1; memWrite = 1; adrSrc = 1; end
      ST_EXEC_R: begin srcA = 2; aluOp = 2; end
      ST_EXEC_I: begin srcA = 2; srcB = 1; aluOp = 2; end
      ST_ALUWB:  regWrite = 1;
      ST_BRANCH: begin srcA = 2; aluOp = 1; branch = 1; end
      ST_JAL:    begin result = 3; regWrite = 1; pcWrite = 1; end
      ST_JALR:   begin srcA = 2; srcB = 1; result = 2; pcWrite = 1; regWrite = 1; end
      ST_UPPER:  begin result = 2; srcA = 1; srcB = 1; regWrite = 1; end
      ST_TRAP:   trap = 1;
      ST_HALT:   halted = 1;
      default:   ;
    endcase
    return {memReq, memWrite, adrSrc, irWrite, pcWrite, branch, regWrite,
            srcA, srcB, aluOp, result, trap, halted};
  endfunction

  function automatic logic [4:0] expImm(input logic [6:0] op, input logic [2:0] f3);
    logic [2:0] imm;
    case (op[6:2])
      5'b00100:           imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'b010 : 3'b001;
      5'b01000:           imm = 3'b011;
      5'b01101, 5'b00101: imm = 3'b100;
      5'b11000:           imm = 3'b101;
      5'b11001:           imm = 3'b110;
      5'b11011:           imm = 3'b111;
      default:            imm = 3'b000;
    endcase
    return {imm, f3[2], ~op[5]};
  endfunction

  task automatic checkOutput(input cyc_t c);
    check($sformatf("state@%0d", c.st), 32'(aState), 32'(c.st));
    check($sformatf("ctrl@%0d", c.st), 32'(aCtrl), 32'(expCtrl(c.st, c.ack)));
    check($sformatf("cause@%0d", c.st), 32'(aTrapCause), 32'(c.cause));
    check($sformatf("imm@%0d", c.st), 32'({aImmSrc, aReadDataSrc, aImmPlusSrc}), 32'(expImm(c.op, c.f3)));
  endtask

  task automatic addCycle(input int st, input logic ack);
    cyc_t c;
    c.st = 4'(st); c.ack = ack; c.cause = curCause; c.op = curOp; c.f3 = curF3;
    stimQ.push_back(c);
  endtask

  task automatic enterTrap(input logic [1:0] cause);
    curCause = cause;
    addCycle(ST_TRAP, 1'b1);
    repeat (3) addCycle(ST_HALT, 1'b1);
  endtask

  // A wait state tolerates up to TO_A ack-less cycles; one more without ack traps.
  task automatic waitPhase(input int st, input int waits, output bit trapped);
    trapped = 1'b0;
    if (TO_A != 0 && waits > TO_A) begin
      for (int i = 0; i <= TO_A; i++) addCycle(st, 1'b0);
      enterTrap(2'b11);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) addCycle(st, 1'b0);
      addCycle(st, 1'b1);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input int fetchWaits, input int memWaits);
    bit tr;
    curOp = op;
    curF3 = f3;
    waitPhase(ST_FETCH, fetchWaits, tr);
    if (tr) return;
    addCycle(ST_DECODE, 1'b1);
    case (op[6:2])
      5'b00000: begin
        addCycle(ST_MEMADR, 1'b1);
        waitPhase(ST_MEMRD, memWaits, tr);
        if (!tr) addCycle(ST_MEMWB, 1'b1);
      end
      5'b01000: begin
        addCycle(ST_MEMADR, 1'b1);
        waitPhase(ST_MEMWR, memWaits, tr);
      end
      5'b01100: begin addCycle(ST_EXEC_R, 1'b1); addCycle(ST_ALUWB, 1'b1); end
      5'b00100: begin addCycle(ST_EXEC_I, 1'b1); addCycle(ST_ALUWB, 1'b1); end
      5'b11000: addCycle(ST_BRANCH, 1'b1);
      5'b11011: addCycle(ST_JAL, 1'b1);
      5'b11001: addCycle(ST_JALR, 1'b1);
      5'b01101, 5'b00101: addCycle(ST_UPPER, 1'b1);
      5'b00011: ;
      5'b11100: enterTrap((SUP_A != 0) ? 2'b10 : 2'b01);
      default:  enterTrap(2'b01);
    endcase
  endtask

  task automatic runQ();
    while (stimQ.size() > 0) begin
      cyc_t c;
      c = stimQ.pop_front();
      @(negedge clk);
      i_opcode = c.op;
      i_funct3 = c.f3;
      i_memAck = c.ack;
      chkQ.push_back(c);
    end
    #3;
  endtask

  // Reset is released just after a rising edge, so the next cycle is observed in IDLE.
  task automatic doReset();
    @(negedge clk);
    i_rst = 1'b1;
    i_memAck = 1'b0;
    #1;
    check("reset state", 32'(aState), 32'd0);
    check("reset ctrl", 32'(aCtrl), 32'd0);
    check("reset cause", 32'(aTrapCause), 32'd0);
    reqCount = 0;
    trapCount = 0;
    curCause = 2'b00;
    @(posedge clk);
    #1 i_rst = 1'b0;
    addCycle(ST_IDLE, 1'b0);
  endtask

  always @(negedge clk) begin
    cyc_t c;
    #2;
    if (aMemReq && aAdrSrc) reqCount++;
    if (aTrap) trapCount++;
    if (chkQ.size() > 0) begin
      c = chkQ.pop_front();
      checkOutput(c);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    applyStimulus(7'b0110011, 3'b000, 0, 0);
    applyStimulus(7'b0000011, 3'b010, 0, 3);
    runQ();
    check("lw memrd req cycles", 32'(reqCount), 32'd4);
    applyStimulus(7'b0000011, 3'b100, 2, 0);
    applyStimulus(7'b0100011, 3'b010, 0, 1);
    applyStimulus(7'b0010011, 3'b000, 0, 0);
    applyStimulus(7'b0010011, 3'b101, 0, 0);
    applyStimulus(7'b0110111, 3'b000, 0, 0);
    applyStimulus(7'b0010111, 3'b000, 0, 0);
    applyStimulus(7'b1100011, 3'b000, 0, 0);
    applyStimulus(7'b1101111, 3'b000, 0, 0);
    applyStimulus(7'b1100111, 3'b000, 0, 0);
    applyStimulus(7'b0001111, 3'b000, 0, 0);
    applyStimulus(7'b0110011, 3'b111, 4, 0);
    applyStimulus(7'b0100011, 3'b010, 0, 4);
    runQ();

    doReset();
    applyStimulus(7'b0100011, 3'b010, 0, 5);
    runQ();
    check("sw timeout trap pulses", 32'(trapCount), 32'd1);
    check("sw timeout cause", 32'(aTrapCause), 32'd3);
    check("sw timeout halted", 32'(aHalted), 32'd1);

    doReset();
    applyStimulus(7'b1111111, 3'b000, 0, 0);
    runQ();
    check("illegal cause", 32'(aTrapCause), 32'd1);

    doReset();
    applyStimulus(7'b1110011, 3'b000, 0, 0);
    runQ();
    check("ecall cause sys=1", 32'(aTrapCause), 32'd2);
    check("ecall cause sys=0", 32'(bTrapCause), 32'd1);
    check("ecall halted sys=0", 32'(bHalted), 32'd1);

    doReset();
    applyStimulus(7'b0110011, 3'b000, 5, 0);
    runQ();

    doReset();
    applyStimulus(7'b0000011, 3'b000, 0, 6);
    runQ();
    check("no-timeout dut halted", 32'(bHalted), 32'd0);
    check("no-timeout dut cause", 32'(bTrapCause), 32'd0);

    doReset();
    curOp = 7'b0100011;
    curF3 = 3'b010;
    addCycle(ST_FETCH, 1'b1);
    addCycle(ST_DECODE, 1'b1);
    addCycle(ST_MEMADR, 1'b1);
    addCycle(ST_MEMWR, 1'b0);
    runQ();
    i_rst = 1'b1;
    #1;
    check("async reset memReq", 32'(aMemReq), 32'd0);
    check("async reset state", 32'(aState), 32'd0);
    check("async reset ctrl", 32'(aCtrl), 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    i_memAck = 1'b0;
    #1;
    check("post reset idle", 32'(aState), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("fetch after release", 32'(aState), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
